spi_cmd_master: RTL and testbench

- Host-side SPI frame generator. Sits directly upstream of spi_wrapper and drives its MOSI/SS_n from parallel command requests.
- Serialises 2-bit command + 8-bit payload frames, MSB first, one bit per clk.
- For read-data commands, also captures the 8-bit MISO reply and returns it on a one-cycle response strobe.
- Shares clk with the slave. There is no separate SCLK; the slave samples on the same clock.

---
 rtl/spi_cmd_pkg.sv | 32 +++
 rtl/spi_frame_shifter.sv | 46 ++++
 rtl/spi_cmd_master.sv | 138 +++++++++++++
 tb/tb_spi_cmd_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared encodings and sizes for the SPI command master.
// Frames are {cmd_type, payload}, shifted MSB first.
package spi_cmd_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_TURN,
    ST_RECV,
    ST_GAP
  } state_e;

  function automatic logic [FRAME_BITS-1:0] make_frame(
    input cmd_e                 t,
    input logic [DATA_BITS-1:0] d
  );
    return {t, d};
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Parallel-load transmit shifter and serial-in receive shifter.
// rx_next exposes the byte as it will look after the next shift_in.
module spi_frame_shifter
  import spi_cmd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift_out,
  input  logic                  shift_in,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  miso,
  output logic                  mosi_bit,
  output logic [DATA_BITS-1:0]  rx_next
);

  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [DATA_BITS-1:0]  rx_q, rx_d;

  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (load) begin
      tx_d = frame;
    end else if (shift_out) begin
      tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
    end
    if (shift_in) begin
      rx_d = rx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  assign mosi_bit = tx_q[FRAME_BITS-1];
  assign rx_next  = {rx_q[DATA_BITS-2:0], miso};

endmodule

// File: rtl/spi_cmd_master.sv
// Host-side SPI frame generator: START, 10-bit SHIFT, optional
// TURN/RECV for read-data, then a GAP with SS_n high.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned MIN_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_type,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 busy,
  output logic                 MOSI,
  output logic                 SS_n,
  input  logic                 MISO
);

  localparam logic [CNT_W-1:0] SHIFT_LD = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] RECV_LD  = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(MIN_GAP - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rd_q, rd_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;

  logic                  load;
  logic                  shift_out;
  logic                  shift_in;
  logic                  last;
  logic                  mosi_bit;
  logic [DATA_BITS-1:0]  rx_next;
  logic [FRAME_BITS-1:0] frame;

  assign last  = (cnt_q == '0);
  assign frame = make_frame(cmd_e'(cmd_type), cmd_data);

  always_comb begin
    state_d     = state_q;
    cnt_d       = last ? cnt_q : cnt_q - 1'b1;
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    load        = 1'b0;
    shift_out   = 1'b0;
    shift_in    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_START;
          cnt_d   = '0;
          load    = 1'b1;
          rd_d    = (cmd_e'(cmd_type) == CMD_RD_DATA);
        end
      end
      ST_START: begin
        state_d = ST_SHIFT;
        cnt_d   = SHIFT_LD;
      end
      ST_SHIFT: begin
        shift_out = 1'b1;
        if (last) begin
          state_d = rd_q ? ST_TURN : ST_GAP;
          cnt_d   = rd_q ? TURN_LD : GAP_LD;
        end
      end
      ST_TURN: begin
        if (last) begin
          state_d = ST_RECV;
          cnt_d   = RECV_LD;
        end
      end
      ST_RECV: begin
        shift_in = 1'b1;
        // Final MISO bit is folded in on the same edge as the strobe.
        if (last) begin
          state_d     = ST_GAP;
          cnt_d       = GAP_LD;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_next;
        end
      end
      ST_GAP: begin
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  spi_frame_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .shift_out (shift_out),
    .shift_in  (shift_in),
    .frame     (frame),
    .miso      (MISO),
    .mosi_bit  (mosi_bit),
    .rx_next   (rx_next)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign SS_n      = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign MOSI      = (state_q == ST_SHIFT) && mosi_bit;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: table vectors, random frames against a
// cycle-timing reference, plus back-to-back and mid-frame reset cases.
module tb_spi_cmd_master;

  localparam int TA = 3;
  localparam int MG = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       mosi;
  logic       ss_n;
  logic       miso;

  always #5 clk = ~clk;

  spi_cmd_master #(.TURNAROUND(TA), .MIN_GAP(MG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .MOSI      (mosi),
    .SS_n      (ss_n),
    .MISO      (miso)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] held_rsp;

  typedef struct {
    logic [1:0] t;
    logic [7:0] d;
    logic [7:0] reply;
    logic [9:0] exp_mosi;
    int         exp_ss;
    logic       exp_rsp;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (cmd_ready !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_frame(input logic [1:0] t, input logic [7:0] d,
                           input logic [7:0] reply, input logic [9:0] exp_mosi,
                           input int exp_ss, input logic exp_rsp,
                           input logic [7:0] exp_data);
    int rd_len, n, ss_low, ss_first, ss_last, rsp_cnt, rsp_k;
    int stray, rdy_early;
    logic [9:0] mw;
    logic rdy_at;
    rd_len = (t == 2'b11) ? TA + 8 : 0;
    n = 12 + MG + rd_len;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_data  = d;
    @(posedge clk);
    mw = '0; ss_low = 0; ss_first = -1; ss_last = -1;
    rsp_cnt = 0; rsp_k = -1; stray = 0; rdy_early = 0; rdy_at = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 1'b0;
        cmd_type  = 2'($urandom);
        cmd_data  = 8'($urandom);
      end
      if (ss_n === 1'b0) begin
        ss_low++;
        if (ss_first < 0) ss_first = k;
        ss_last = k;
      end
      if (k >= 2 && k <= 11) mw = {mw[8:0], mosi};
      else if (mosi !== 1'b0) stray++;
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        rsp_k = k;
      end
      if (k < n && cmd_ready !== 1'b0) rdy_early++;
      if (k == n) rdy_at = cmd_ready;
      if (t == 2'b11 && k >= 12 + TA && k <= 19 + TA)
        miso = reply[19 + TA - k];
      else
        miso = 1'($urandom);
    end
    check("mosi_bits", 32'(mw), 32'(exp_mosi));
    check("ss_first", ss_first, 1);
    check("ss_last", ss_last, exp_ss);
    check("ss_low_len", ss_low, exp_ss);
    check("mosi_idle", stray, 0);
    check("rsp_count", rsp_cnt, exp_rsp ? 1 : 0);
    check("rsp_cycle", rsp_k, exp_rsp ? 20 + TA : -1);
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("ready_low", rdy_early, 0);
    check("ready_back", 32'(rdy_at), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic model_frame(input logic [1:0] t, input logic [7:0] d,
                             input logic [7:0] reply);
    logic rd;
    rd = (t == 2'b11);
    if (rd) held_rsp = reply;
    run_frame(t, d, reply, {t, d}, rd ? 19 + TA : 11, rd, held_rsp);
  endtask

  initial begin
    int fall1, rise1, fall2, rdy_in_frame, guard;
    logic prev;
    logic [9:0] fr;

    vecs[0] = '{2'b00, 8'hF1, 8'h5A, 10'b00_1111_0001, 11, 1'b0, 8'h00};
    vecs[1] = '{2'b01, 8'h77, 8'h3C, 10'b01_0111_0111, 11, 1'b0, 8'h00};
    vecs[2] = '{2'b10, 8'hF1, 8'h00, 10'b10_1111_0001, 11, 1'b0, 8'h00};
    vecs[3] = '{2'b11, 8'h00, 8'hA5, 10'b11_0000_0000, 22, 1'b1, 8'hA5};
    vecs[4] = '{2'b00, 8'h12, 8'hFF, 10'b00_0001_0010, 11, 1'b0, 8'hA5};
    vecs[5] = '{2'b01, 8'h34, 8'h00, 10'b01_0011_0100, 11, 1'b0, 8'hA5};
    vecs[6] = '{2'b11, 8'hFF, 8'h3C, 10'b11_1111_1111, 22, 1'b1, 8'h3C};

    rst_n = 1'b0; cmd_valid = 1'b1; cmd_type = 2'b11;
    cmd_data = 8'h00; miso = 1'b0; held_rsp = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ss", 32'(ss_n), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].t, vecs[i].d, vecs[i].reply, vecs[i].exp_mosi,
                vecs[i].exp_ss, vecs[i].exp_rsp, vecs[i].exp_data);
      held_rsp = vecs[i].exp_data;
    end

    // Back-to-back writes with cmd_valid held high
    wait_ready();
    cmd_valid = 1'b1; cmd_type = 2'b01; cmd_data = 8'h55;
    fall1 = -1; rise1 = -1; fall2 = -1; rdy_in_frame = 0;
    prev = 1'b1;
    for (int k = 1; k <= 80 && fall2 < 0; k++) begin
      @(negedge clk);
      if (ss_n === 1'b0 && cmd_ready !== 1'b0) rdy_in_frame++;
      if (prev === 1'b1 && ss_n === 1'b0) begin
        if (fall1 < 0) fall1 = k;
        else fall2 = k;
      end
      if (prev === 1'b0 && ss_n === 1'b1 && rise1 < 0) rise1 = k;
      prev = ss_n;
    end
    cmd_valid = 1'b0;
    check("b2b_found", 32'(fall2 > 0), 32'd1);
    check("b2b_frame_len", rise1 - fall1, 11);
    check("b2b_high_cycles", fall2 - rise1, MG + 1);
    check("b2b_ready_in_frame", rdy_in_frame, 0);

    // Reset during SHIFT bit 4 of a read-data frame
    wait_ready();
    cmd_valid = 1'b1; cmd_type = 2'b11; cmd_data = 8'hC3;
    fr = {2'b11, 8'hC3};
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
    end
    check("pre_rst_mosi_bit4", 32'(mosi), 32'(fr[4]));
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_ss", 32'(ss_n), 32'd1);
    check("mid_rst_mosi", 32'(mosi), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    check("rst_ignores_valid", 32'(busy), 32'd0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    held_rsp = 8'h00;
    @(negedge clk);
    model_frame(2'b00, 8'hF1, 8'h99);
    model_frame(2'b11, 8'h00, 8'hA5);
    model_frame(2'b01, 8'h0F, 8'h11);
    model_frame(2'b00, 8'hE2, 8'h22);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model_frame(2'($urandom), 8'($urandom), 8'($urandom));
    end

    guard = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
